// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: data-memory bus shared by the core (master) and responders (slave)
// signals: WriteEn, address, datain, datasize, datatype driven by the core; dataout returned by the responder
interface mmio_uart_tx_if;
   logic        WriteEn;
   logic [31:0] address;
   logic [31:0] datain;
   logic [1:0]  datasize;
   logic        datatype;
   logic [31:0] dataout;
   modport master (output WriteEn, address, datain, datasize, datatype, input dataout);
   modport slave (input WriteEn, address, datain, datasize, datatype, output dataout);
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO and combinational status reads
// ports: clk; reset (async, active-high); bus (slave side of the data-memory bus); tx (serial out, idle high)
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic           clk,
   input  logic           reset,
   mmio_uart_tx_if.slave  bus,
   output logic           tx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int BW = $clog2(CLKS_PER_BIT);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t        state;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [BW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic [31:0]   status;
   logic          overflow, sel, wr_data, wr_stat, full, empty, push, pop, bit_done, unused;
   assign sel      = bus.address[31:3] == BASE_ADDR[31:3];
   assign wr_data  = sel & bus.WriteEn & ~bus.address[2];
   assign wr_stat  = sel & bus.WriteEn & bus.address[2];
   assign full     = count == CW'(FIFO_DEPTH);
   assign empty    = count == '0;
   assign push     = wr_data & ~full;
   assign bit_done = bit_cnt == BW'(CLKS_PER_BIT - 1);
   // the serializer pops when idle or at the end of a stop bit, so back-to-back frames have no gap
   assign pop      = ~empty & (state == IDLE | (state == STOP & bit_done));
   assign status   = {{(25 - CW){1'b0}}, count, 3'b000, overflow, empty, full, state != IDLE};
   assign bus.dataout = sel & bus.address[2] ? status : 32'h0;
   assign unused   = ^{bus.datasize, bus.datatype, bus.address[1:0], bus.datain[31:8]};
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= bus.datain[7:0];
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
         if (wr_data & full) overflow <= 1'b1;
         else if (wr_stat & bus.datain[3]) overflow <= 1'b0;
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state   <= IDLE;
         tx      <= 1'b1;
         shift   <= '0;
         bit_cnt <= '0;
         bit_idx <= '0;
      end else begin
         bit_cnt <= bit_done || state == IDLE ? '0 : bit_cnt + BW'(1);
         case (state)
            IDLE:
               if (pop) begin
                  shift <= mem[rd_ptr];
                  state <= START;
                  tx    <= 1'b0;
               end
            START:
               if (bit_done) begin
                  state   <= DATA;
                  bit_idx <= '0;
                  tx      <= shift[0];
               end
            DATA:
               if (bit_done) begin
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     tx    <= 1'b1;
                  end else begin
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            STOP:
               if (bit_done) begin
                  if (pop) begin
                     shift <= mem[rd_ptr];
                     state <= START;
                     tx    <= 1'b0;
                  end else state <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench for mmio_uart_tx; a serial receiver pops expected bytes as frames arrive
module tb_mmio_uart_tx;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int CPB = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tx;
   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [7:0] sb[$];
   int starts[$];
   logic rx_on = 1'b0;
   int rx_cnt = 0;
   logic [7:0] rx_byte = '0;
   logic [7:0] rx_exp;
   mmio_uart_tx_if bus();
   mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .bus(bus), .tx(tx));
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (reset) rx_on = 1'b0;
      else if (!rx_on) begin
         if (tx === 1'b0) begin
            rx_on = 1'b1;
            rx_cnt = 0;
            starts.push_back(cyc);
         end
      end else begin
         rx_cnt++;
         if (rx_cnt == 2) begin
            total++;
            if (tx !== 1'b0) begin bad++; $display("FAIL start_bit got=%b want=0", tx); end
         end else if (rx_cnt >= CPB + 2 && rx_cnt <= 8 * CPB + 2 && rx_cnt % CPB == 2)
            rx_byte = {tx, rx_byte[7:1]};
         else if (rx_cnt == 9 * CPB + 2) begin
            total++;
            if (tx !== 1'b1) begin bad++; $display("FAIL stop_bit got=%b want=1", tx); end
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL rx_byte got=%02h want=none", rx_byte); end
            else begin
               rx_exp = sb.pop_front();
               if (rx_byte !== rx_exp) begin bad++; $display("FAIL rx_byte got=%02h want=%02h", rx_byte, rx_exp); end
            end
            rx_on = 1'b0;
         end
      end
   end
   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.WriteEn = 1'b1;
      bus.address = a;
      bus.datain = d;
      @(posedge clk); #1;
      bus.WriteEn = 1'b0;
      bus.address = 32'h0;
      bus.datain = 32'h0;
   endtask
   task automatic send(input logic [7:0] b);
      sb.push_back(b);
      wr(BASE, {24'h0, b});
   endtask
   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      bus.address = a;
      #1 v = bus.dataout;
      bus.address = 32'h0;
   endtask
   task automatic wait_idle(input int limit);
      int n = 0;
      logic [31:0] v;
      logic ok = 1'b0;
      while (!ok && n < limit) begin
         tick(1);
         rd(BASE + 4, v);
         ok = v == 32'h4 && sb.size() == 0 && !rx_on;
         n++;
      end
      total++;
      if (!ok) begin bad++; $display("FAIL idle_timeout status=%h pending=%0d want status=4 pending=0", v, sb.size()); end
   endtask
   task automatic test_reset();
      logic [31:0] v;
      tick(3);
      total++;
      if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
      rd(BASE + 4, v);
      total++;
      if (v !== 32'h4) begin bad++; $display("FAIL reset_status got=%h want=4", v); end
      reset = 1'b0;
      tick(1);
      rd(BASE, v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL txdata_read got=%h want=0", v); end
      rd(BASE + 4, v);
      total++;
      if (v !== 32'h4) begin bad++; $display("FAIL post_reset_status got=%h want=4", v); end
   endtask
   task automatic test_single();
      logic [31:0] v;
      send(8'h55);
      rd(BASE + 4, v);
      total++;
      if (v !== 32'h80) begin bad++; $display("FAIL single_queued got=%h want=80", v); end
      total++;
      if (tx !== 1'b1) begin bad++; $display("FAIL single_not_started got=%b want=1", tx); end
      tick(1);
      rd(BASE + 4, v);
      total++;
      if (v !== 32'h5) begin bad++; $display("FAIL single_busy got=%h want=5", v); end
      total++;
      if (tx !== 1'b0) begin bad++; $display("FAIL single_start got=%b want=0", tx); end
      tick(CPB);
      total++;
      if (tx !== 1'b1) begin bad++; $display("FAIL single_bit0 got=%b want=1", tx); end
      wait_idle(100);
   endtask
   task automatic test_back_to_back();
      logic [31:0] v;
      starts.delete();
      send(8'hA5);
      rd(BASE + 4, v);
      total++;
      if (v !== 32'h80) begin bad++; $display("FAIL b2b_first got=%h want=80", v); end
      send(8'h3C);
      rd(BASE + 4, v);
      total++;
      if (v !== 32'h81) begin bad++; $display("FAIL b2b_second got=%h want=81", v); end
      tick(10 * CPB - 1);
      rd(BASE + 4, v);
      total++;
      if (v !== 32'h81) begin bad++; $display("FAIL b2b_frame1_end got=%h want=81", v); end
      tick(1);
      rd(BASE + 4, v);
      total++;
      if (v !== 32'h5) begin bad++; $display("FAIL b2b_frame2 got=%h want=5", v); end
      tick(10 * CPB - 1);
      rd(BASE + 4, v);
      total++;
      if (v !== 32'h5) begin bad++; $display("FAIL b2b_frame2_end got=%h want=5", v); end
      tick(1);
      rd(BASE + 4, v);
      total++;
      if (v !== 32'h4) begin bad++; $display("FAIL b2b_idle got=%h want=4", v); end
      total++;
      if (starts.size() != 2 || starts[1] - starts[0] != 10 * CPB) begin
         bad++;
         $display("FAIL b2b_gap frames=%0d gap=%0d want frames=2 gap=%0d", starts.size(),
                  starts.size() == 2 ? starts[1] - starts[0] : -1, 10 * CPB);
      end
   endtask
   task automatic test_overflow();
      logic [31:0] v;
      for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
      wr(BASE, 32'hEE);
      rd(BASE + 4, v);
      total++;
      if (v !== 32'h40B) begin bad++; $display("FAIL ovf_full got=%h want=40b", v); end
      wr(BASE + 4, 32'hFFFF_FFF7);
      rd(BASE + 4, v);
      total++;
      if (v !== 32'h40B) begin bad++; $display("FAIL ovf_no_clear got=%h want=40b", v); end
      wr(BASE + 4, 32'h8);
      rd(BASE + 4, v);
      total++;
      if (v !== 32'h403) begin bad++; $display("FAIL ovf_clear got=%h want=403", v); end
      wait_idle(9 * 10 * CPB + 50);
   endtask
   task automatic test_decode();
      logic [31:0] v;
      wr(BASE + 8, 32'h77);
      wr(BASE - 4, 32'h66);
      rd(BASE + 4, v);
      total++;
      if (v !== 32'h4) begin bad++; $display("FAIL dec_no_push got=%h want=4", v); end
      rd(BASE + 8, v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL dec_above got=%h want=0", v); end
      rd(BASE - 4, v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL dec_below got=%h want=0", v); end
      tick(1);
      rd(BASE + 7, v);
      total++;
      if (v !== 32'h4) begin bad++; $display("FAIL dec_low_bits got=%h want=4", v); end
      tick(5);
      total++;
      if (tx !== 1'b1 || rx_on) begin bad++; $display("FAIL dec_tx_idle got=%b want=1", tx); end
   endtask
   task automatic test_reset_mid();
      logic [31:0] v;
      send(8'hC3);
      tick(1 + 4 * CPB + 1);
      total++;
      if (tx !== 1'b0) begin bad++; $display("FAIL mid_bit3 got=%b want=0", tx); end
      #2 reset = 1'b1;
      #1;
      total++;
      if (tx !== 1'b1) begin bad++; $display("FAIL mid_reset_tx got=%b want=1", tx); end
      rd(BASE + 4, v);
      total++;
      if (v !== 32'h4) begin bad++; $display("FAIL mid_reset_status got=%h want=4", v); end
      sb.delete();
      tick(2);
      reset = 1'b0;
      tick(1);
      send(8'h5A);
      wait_idle(100);
   endtask
   task automatic test_wrap();
      logic [31:0] v;
      for (int i = 0; i < 20; i++) begin
         int n = 0;
         rd(BASE + 4, v);
         while (v[1] && n < 100) begin
            tick(1);
            rd(BASE + 4, v);
            n++;
         end
         total++;
         if (v[1]) begin bad++; $display("FAIL wrap_full_timeout got=%h want=bit1 clear", v); end
         send(8'(i));
      end
      wait_idle(20 * 10 * CPB + 100);
   endtask
   initial begin
      bus.WriteEn = 1'b0;
      bus.address = 32'h0;
      bus.datain = 32'h0;
      bus.datasize = 2'b10;
      bus.datatype = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_decode();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
